// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one single-port memory.
// One transaction in flight at a time: grant in IDLE, memory access in REQ, response in RESP.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_BF,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       conflict_cnt
);

    localparam int unsigned StreakW = $clog2(MAX_STREAK + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_STREAK);
    localparam logic OwnerIf = 1'b0;
    localparam logic OwnerLs = 1'b1;

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [StreakW-1:0]  streak_q, streak_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                suppress_q, suppress_d;
    logic                grant_if, grant_ls, if_ok, lose;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        streak_d   = streak_q;
        suppress_d = suppress_q;
        grant_if   = 1'b0;
        grant_ls   = 1'b0;
        // A flushed fetch is not eligible, so it cannot force a streak break either.
        if_ok      = if_req && !flush;

        case (state_q)
            StIdle: begin
                if (ls_req && !(if_ok && streak_q >= StreakMax)) begin
                    grant_ls = 1'b1;
                    owner_d  = OwnerLs;
                    addr_d   = ls_addr;
                    we_d     = ls_we;
                    wdata_d  = ls_wdata;
                    state_d  = StReq;
                    if (if_req) begin
                        streak_d = (streak_q >= StreakMax) ? streak_q : streak_q + 1'b1;
                    end else begin
                        streak_d = '0;
                    end
                end else if (if_ok) begin
                    grant_if = 1'b1;
                    owner_d  = OwnerIf;
                    addr_d   = if_addr;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    streak_d = '0;
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (flush && owner_q == OwnerIf) begin
                    suppress_d = 1'b1;
                end
                if (mem_ready) begin
                    rdata_d = mem_rdata;
                    state_d = StResp;
                end
            end
            StResp: begin
                suppress_d = 1'b0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase

        lose  = (if_req && !grant_if) || (ls_req && !grant_ls);
        cnt_d = (lose && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst_BF) begin
            state_q    <= StIdle;
            owner_q    <= OwnerIf;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            streak_q   <= '0;
            cnt_q      <= '0;
            suppress_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            streak_q   <= streak_d;
            cnt_q      <= cnt_d;
            suppress_q <= suppress_d;
        end
    end

    // Outputs are forced low combinationally so reset silences them before the edge.
    assign if_gnt       = grant_if && !rst_BF;
    assign ls_gnt       = grant_ls && !rst_BF;
    assign mem_req      = (state_q == StReq) && !rst_BF;
    assign mem_we       = we_q && !rst_BF;
    assign mem_addr     = rst_BF ? '0 : addr_q;
    assign mem_wdata    = rst_BF ? '0 : wdata_q;
    assign if_rvalid    = !rst_BF && (state_q == StResp) && (owner_q == OwnerIf) &&
                          !suppress_q && !flush;
    assign ls_rvalid    = !rst_BF && (state_q == StResp) && (owner_q == OwnerLs);
    assign if_rdata     = rst_BF ? '0 : rdata_q;
    assign ls_rdata     = rst_BF ? '0 : rdata_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 time unit after the rising edge,
// outputs are checked 1 time unit later, well clear of the next edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_BF;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [15:0] conflict_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4)) dut (
        .clk          (clk),
        .rst_BF       (rst_BF),
        .flush        (flush),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .ls_req       (ls_req),
        .ls_we        (ls_we),
        .ls_addr      (ls_addr),
        .ls_wdata     (ls_wdata),
        .ls_gnt       (ls_gnt),
        .ls_rvalid    (ls_rvalid),
        .ls_rdata     (ls_rdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_BF = 1'b1;
        tick();
        tick();
        rst_BF = 1'b0;
    endtask

    initial begin
        logic exp_ls [6];
        int   k;

        rst_BF = 1'b1; flush = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;

        // Reset: outputs silent even with requests and a ready memory present.
        tick();
        if_req = 1'b1; ls_req = 1'b1; mem_ready = 1'b1; ls_addr = 32'hABC; ls_wdata = 32'h77;
        settle();
        check("rst_if_gnt", if_gnt, 0);
        check("rst_ls_gnt", ls_gnt, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        tick();
        rst_BF = 1'b0; if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b0;
        settle();
        check("rst_cnt", conflict_cnt, 0);
        check("rst_rvalid", {if_rvalid, ls_rvalid}, 0);

        // IF-only fetch, single-cycle memory.
        if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1; mem_rdata = 32'h13;
        settle();
        check("if_gnt_N", if_gnt, 1);
        check("if_ls_gnt_N", ls_gnt, 0);
        check("if_memreq_N", mem_req, 0);
        tick();
        if_req = 1'b0;
        settle();
        check("if_memreq_N1", mem_req, 1);
        check("if_memaddr_N1", mem_addr, 32'h100);
        check("if_memwe_N1", mem_we, 0);
        check("if_rvalid_N1", if_rvalid, 0);
        tick();
        settle();
        check("if_rvalid_N2", if_rvalid, 1);
        check("if_rdata_N2", if_rdata, 32'h13);
        check("if_lsrv_N2", ls_rvalid, 0);
        check("if_memreq_N2", mem_req, 0);
        tick();
        settle();
        check("if_rvalid_N3", if_rvalid, 0);
        check("if_cnt", conflict_cnt, 0);
        exp_cnt = 0;

        // Store with memory ready delayed by three REQ cycles.
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h5E4; ls_wdata = 32'h14; mem_ready = 1'b0;
        mem_rdata = 32'hDEAD;
        settle();
        check("st_gnt", ls_gnt, 1);
        tick();
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("st_memreq", mem_req, 1);
            check("st_fields", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h5E4, 32'h14});
            check("st_rvalid", ls_rvalid, 0);
            tick();
        end
        mem_ready = 1'b1;
        settle();
        check("st_memreq4", mem_req, 1);
        tick();
        mem_ready = 1'b0;
        settle();
        check("st_ls_rvalid", ls_rvalid, 1);
        check("st_if_rvalid", if_rvalid, 0);
        tick();
        settle();
        check("st_rvalid_end", ls_rvalid, 0);

        // Continuous contention: four LSU grants, one IF grant, then LSU.
        exp_ls = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        if_req = 1'b1; if_addr = 32'h400; ls_req = 1'b1; ls_addr = 32'h80; mem_ready = 1'b1;
        k = 0;
        for (int cyc = 0; cyc < 40 && k < 6; cyc++) begin
            settle();
            if (if_gnt || ls_gnt) begin
                check("streak_order", {if_gnt, ls_gnt}, exp_ls[k] ? 2'b01 : 2'b10);
                k++;
            end
            exp_cnt++;
            tick();
            check("streak_cnt", conflict_cnt, exp_cnt);
        end
        check("streak_grants", k, 6);
        if_req = 1'b0; ls_req = 1'b0;
        tick();
        tick();
        settle();
        check("streak_cnt_end", conflict_cnt, exp_cnt);

        // IF flushed mid-REQ: transaction completes silently.
        if_req = 1'b1; if_addr = 32'h200; mem_ready = 1'b0; mem_rdata = 32'hBAD;
        settle();
        check("fl_gnt", if_gnt, 1);
        tick();
        if_req = 1'b0; flush = 1'b1;
        settle();
        check("fl_memreq1", mem_req, 1);
        tick();
        flush = 1'b0; mem_ready = 1'b1;
        settle();
        check("fl_memreq2", mem_req, 1);
        tick();
        mem_ready = 1'b0;
        settle();
        check("fl_rvalid", if_rvalid, 0);
        tick();
        // Flush in IDLE blocks IF but not the LSU.
        if_req = 1'b1; if_addr = 32'h300; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h44;
        flush = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h66;
        settle();
        check("fl_idle_gnt", {if_gnt, ls_gnt}, 2'b01);
        exp_cnt++;
        tick();
        ls_req = 1'b0; flush = 1'b0;
        exp_cnt++;
        tick();
        settle();
        check("fl_ls_rvalid", {if_rvalid, ls_rvalid}, 2'b01);
        check("fl_ls_rdata", ls_rdata, 32'h66);
        exp_cnt++;
        tick();
        mem_rdata = 32'h55;
        settle();
        check("fl_next_gnt", if_gnt, 1);
        tick();
        if_req = 1'b0;
        tick();
        settle();
        check("fl_next_rvalid", if_rvalid, 1);
        check("fl_next_rdata", if_rdata, 32'h55);
        check("fl_cnt", conflict_cnt, exp_cnt);
        tick();

        // Reset during REQ abandons the load.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40; mem_ready = 1'b0; mem_rdata = 32'h99;
        settle();
        check("rm_gnt", ls_gnt, 1);
        tick();
        ls_req = 1'b0; ls_addr = '0;
        settle();
        check("rm_memreq", mem_req, 1);
        rst_BF = 1'b1;
        settle();
        check("rm_memreq_rst", mem_req, 0);
        check("rm_memaddr_rst", mem_addr, 0);
        tick();
        rst_BF = 1'b0; mem_ready = 1'b1;
        settle();
        check("rm_memreq_after", mem_req, 0);
        check("rm_rvalid_a", {if_rvalid, ls_rvalid}, 0);
        tick();
        settle();
        check("rm_rvalid_b", {if_rvalid, ls_rvalid}, 0);
        check("rm_cnt", conflict_cnt, 0);

        // Saturation of the conflict counter.
        do_reset();
        if_req = 1'b1; ls_req = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        check("sat_fffe", conflict_cnt, 16'hFFFE);
        tick();
        check("sat_ffff", conflict_cnt, 16'hFFFF);
        for (int i = 0; i < 5; i++) tick();
        check("sat_hold", conflict_cnt, 16'hFFFF);
        if_req = 1'b0; ls_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter MAX_STREAK, default 4, the maximum number of consecutive LSU grants allowed while IF waits.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_BF  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  in  1  pipeline flush (branch mispredict); cancels IF response delivery.
REQ-007 SHALL have ports if_req / if_addr  in  1 / ADDR_W  instruction-fetch read request, held stable until if_gnt.
REQ-008 SHALL have ports if_gnt / if_rvalid / if_rdata  out  1 / 1 / DATA_W  IF grant pulse, response pulse and read data.
REQ-009 SHALL have ports ls_req / ls_we / ls_addr / ls_wdata  in  1 / 1 / ADDR_W / DATA_W  load/store request, held stable until ls_gnt.
REQ-010 SHALL have ports ls_gnt / ls_rvalid / ls_rdata  out  1 / 1 / DATA_W  LSU grant pulse, response pulse (load data or store ack) and read data.
REQ-011 SHALL have ports mem_req / mem_we / mem_addr / mem_wdata  out  1 / 1 / ADDR_W / DATA_W  single-port memory request, held until accepted.
REQ-012 SHALL have ports mem_ready / mem_rdata  in  1 / DATA_W  memory completion strobe and read data, valid together.
REQ-013 SHALL have port conflict_cnt  out  16  saturating count of cycles in which a request lost arbitration.

Function
REQ-014 SHALL implement FSM states IDLE, REQ and RESP, plus a 1-bit owner register (IF or LS).
REQ-015 In IDLE, if any request is present, SHALL select a winner, pulse its gnt combinationally in that same cycle, latch owner, address, write enable and write data, and move to REQ.
REQ-016 In REQ, SHALL drive mem_req=1 with the latched fields, and on mem_ready=1 SHALL capture mem_rdata and move to RESP.
REQ-017 In RESP, SHALL assert the owner's rvalid for exactly one cycle with the captured data, then return to IDLE.
REQ-018 SHALL give a single-cycle memory (mem_ready high in the first REQ cycle) gnt at cycle N, mem_req at N+1, rvalid at N+2, and the next grant no earlier than N+3.
REQ-019 SHALL have the LSU win by default when both request.
REQ-020 SHALL keep a streak counter: +1 on each LSU grant with if_req=1, cleared on an IF grant or on an LSU grant with if_req=0; when both request and streak==MAX_STREAK, IF SHALL win.
REQ-021 SHALL ignore mem_ready outside REQ.
REQ-022 SHALL keep rvalid and gnt low in all states other than those defined above.
REQ-023 When flush=1 in any cycle while owner=IF in REQ or RESP, SHALL let the memory transaction complete but suppress if_rvalid for that transaction; no later response revives it.
REQ-024 When flush=1 in IDLE, SHALL not grant IF that cycle; the LSU may still be granted.
REQ-025 SHALL not let flush affect LSU transactions.
REQ-026 SHALL increment conflict_cnt by 1 in each cycle where a request is high but not granted (including waiting while busy), and SHALL saturate it at 0xFFFF.
REQ-027 SHALL hold mem_addr, mem_we and mem_wdata constant throughout REQ.

Reset
REQ-028 While rst_BF=1 at a clock edge, SHALL set FSM=IDLE, streak=0, conflict_cnt=0, captured data=0, and flush-suppress flag=0.
REQ-029 While rst_BF=1, SHALL hold all outputs (gnt, rvalid, mem_req, mem_we, mem_addr, mem_wdata, rdata) at 0.
REQ-030 When rst_BF=1 mid-transaction, SHALL abandon the transaction with no rvalid, deassert mem_req after the reset edge, and ignore any subsequent mem_ready.

Verification
REQ-031 The bench SHALL cover: IF only, if_addr=0x100, mem_ready on first REQ cycle, mem_rdata=0x00000013 -> if_gnt at N, if_rvalid=1 with if_rdata=0x00000013 at N+2.
REQ-032 The bench SHALL cover: both requesting continuously, MAX_STREAK=4 -> grant order LS,LS,LS,LS,IF,LS...; conflict_cnt increases every waiting cycle.
REQ-033 The bench SHALL cover: LSU store ls_addr=0x5E4, wdata=0x14, mem_ready delayed 3 cycles -> mem_we=1 with fields stable for 3 cycles, then ls_rvalid pulse.
REQ-034 The bench SHALL cover: IF granted, flush=1 during REQ -> mem transaction completes, if_rvalid stays 0, next grant proceeds normally.
REQ-035 The bench SHALL cover: rst_BF=1 during REQ, then mem_ready=1 after reset -> no rvalid, mem_req=0, conflict_cnt=0.
REQ-036 The bench SHALL cover: conflict_cnt preloaded near 0xFFFF via sustained contention -> holds at 0xFFFF.
